// File: rtl/cla_16_bit_ripple_pkg.sv
// Shared constants and the registered result type for the 16-bit
// block-ripple carry-lookahead adder.
package cla_16_bit_ripple_pkg;

    localparam int WIDTH      = 16;
    localparam int BLOCK_W    = 4;
    localparam int NUM_BLOCKS = WIDTH / BLOCK_W;

    // Registered adder result: carry-out above the 16-bit sum.
    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] sum;
    } result_t;

endpackage : cla_16_bit_ripple_pkg

// File: rtl/cla_16_bit_ripple_cla_4_bit.sv
// 4-bit carry-lookahead block. Every internal carry is a flat
// generate/propagate equation of the block carry-in, so no carry
// passes from one bit to the next inside the block.
module cla_4_bit
    import cla_16_bit_ripple_pkg::*;
(
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] sum,
    output logic               cout
);

    logic [BLOCK_W-1:0] g;
    logic [BLOCK_W-1:0] p;
    logic [BLOCK_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries, each expanded back to the block carry-in.
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule : cla_4_bit

// File: rtl/cla_16_bit_ripple.sv
// 16-bit adder: four 4-bit lookahead blocks with the block carries
// rippling c4 -> c8 -> c12 -> cout, followed by a single output register.
module cla_16_bit_ripple
    import cla_16_bit_ripple_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [NUM_BLOCKS:0] carry;
    logic [WIDTH-1:0]    sum_comb;

    result_t result_d;
    result_t result_q;
    logic    valid_d;
    logic    valid_q;

    assign carry[0] = cin;

    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_block
        cla_4_bit u_cla (
            .a    (a[k*BLOCK_W +: BLOCK_W]),
            .b    (b[k*BLOCK_W +: BLOCK_W]),
            .cin  (carry[k]),
            .sum  (sum_comb[k*BLOCK_W +: BLOCK_W]),
            .cout (carry[k+1])
        );
    end

    // Next state: load a fresh result on valid input, otherwise hold it.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a signal unassigned, which would infer a latch.
        result_d = result_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            result_d.sum  = sum_comb;
            result_d.cout = carry[NUM_BLOCKS];
            valid_d       = 1'b1;
        end
    end

    // Output register; reset clears the data too, since a cleared sum/cout
    // is part of the visible reset state, not just the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignment so every register samples its
            // pre-edge value, independent of statement order.
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign sum       = result_q.sum;
    assign cout      = result_q.cout;
    assign out_valid = valid_q;

endmodule : cla_16_bit_ripple

// File: tb/tb_cla_16_bit_ripple.sv
// Scoreboard bench for cla_16_bit_ripple: the driver pushes the expected
// {cout,sum} for every valid input, a monitor pops it when out_valid shows.
module tb_cla_16_bit_ripple;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;

    int tests;
    int fails;

    logic [16:0] exp_q[$];

    cla_16_bit_ripple dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%05h, expected 0x%05h", name, act, req);
        end
    endtask

    // Issue one valid add; the expected value is supplied by the caller.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [16:0] expv);
        @(negedge clk);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        exp_q.push_back(expv);
    endtask

    // Idle cycle with changing operands; outputs must hold.
    task automatic idle(input logic [15:0] va, input logic [15:0] vb,
                        input logic [16:0] hold);
        @(negedge clk);
        in_valid = 1'b0;
        a        = va;
        b        = vb;
        cin      = 1'b1;
        @(posedge clk);
        #1;
        check("idle_hold", {cout, sum}, hold);
        check("idle_valid", {16'h0, out_valid}, 17'h0);
    endtask

    // Monitor: compare each presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {cout, sum}, 17'h1_ffff ^ {cout, sum});
            end else begin
                check("result", {cout, sum}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b1;

        // Reset state, with in_valid high to show it is ignored in reset.
        @(posedge clk);
        #1;
        check("reset_data", {cout, sum}, 17'h0);
        check("reset_valid", {16'h0, out_valid}, 17'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed vectors.
        issue(16'hFF3F, 16'h5555, 1'b0, 17'h1_5494);
        issue(16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
        issue(16'h1234, 16'h4321, 1'b0, 17'h0_5555);
        issue(16'h7FFF, 16'h0001, 1'b0, 17'h0_8000);
        idle(16'hAAAA, 16'h5555, 17'h0_8000);
        idle(16'h0F0F, 16'hF0F1, 17'h0_8000);
        issue(16'h0000, 16'h0000, 1'b0, 17'h0_0000);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
        issue(16'h000F, 16'h0001, 1'b0, 17'h0_0010);
        issue(16'h0FFF, 16'h0000, 1'b1, 17'h0_1000);
        issue(16'h8000, 16'h8000, 1'b0, 17'h1_0000);
        idle(16'h1111, 16'h2222, 17'h1_0000);

        // Result present, then reset between edges with a vector in flight.
        issue(16'h1234, 16'h1111, 1'b1, 17'h0_2346);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'hAAAA;
        cin      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_data", {cout, sum}, 17'h0);
        check("async_reset_valid", {16'h0, out_valid}, 17'h0);
        @(posedge clk);
        #1;
        check("reset_ignores_valid", {out_valid, sum}, 17'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        issue(16'h0101, 16'h0202, 1'b0, 17'h0_0303);

        // Random back-to-back vectors, expected from plain 17-bit addition.
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc));
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 17'(exp_q.size()), 17'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cla_16_bit_ripple
